// File: rtl/hazard_forward_unit.sv
// ID-stage operand bypass resolver and load-use stall sequencer for the 5-stage core.
// Latency: forward_sel 1 cycle (ID -> EX), stall/bubble/id_rf_bypass same cycle; no backpressure input, stall is the backpressure out.
module hazard_forward_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          ex_reg_write,
  input  logic                          ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         ex_write_register,
  input  logic                          me_reg_write,
  input  logic [REG_ADDR_W-1:0]         me_write_register,
  input  logic                          wb_reg_write,
  input  logic [REG_ADDR_W-1:0]         wb_write_register,
  input  logic                          flush,
  output logic                          stall,
  output logic                          bubble,
  output logic [2*NUM_SRC-1:0]          forward_sel,
  output logic [NUM_SRC-1:0]            id_rf_bypass,
  output logic [CNT_W-1:0]              stall_cycles
);

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  localparam logic [2:0]       CNT_INIT = 3'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  state_t                 state, state_d;
  logic [2:0]             cnt, cnt_d;
  logic                   stall_i;
  logic                   hazard;
  logic [NUM_SRC-1:0]     m_ex, m_me, byp_raw;
  logic [2*NUM_SRC-1:0]   fsel_d;

  // Register 0 never carries a real dependency when it is hardwired.
  function automatic logic dest_ok(input logic [REG_ADDR_W-1:0] d);
    return (ZERO_REG_EN == 0) || (d != '0);
  endfunction

  always_comb begin
    m_ex    = '0;
    m_me    = '0;
    byp_raw = '0;
    fsel_d  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      m_ex[k] = id_valid && id_src_used[k] && ex_reg_write && dest_ok(ex_write_register) &&
                (ex_write_register == id_src_addr[k*REG_ADDR_W +: REG_ADDR_W]);
      m_me[k] = id_valid && id_src_used[k] && me_reg_write && dest_ok(me_write_register) &&
                (me_write_register == id_src_addr[k*REG_ADDR_W +: REG_ADDR_W]);
      byp_raw[k] = id_src_used[k] && wb_reg_write && dest_ok(wb_write_register) &&
                   (wb_write_register == id_src_addr[k*REG_ADDR_W +: REG_ADDR_W]);
      // A load in ID/EX has no data yet; that case is a hazard, never 10.
      if (m_ex[k] && !ex_mem_read) begin
        fsel_d[2*k +: 2] = 2'b10;
      end else if (m_me[k]) begin
        fsel_d[2*k +: 2] = 2'b01;
      end
    end
  end

  assign hazard = ex_mem_read && (|m_ex);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    stall_i = 1'b0;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard) begin
            stall_i = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = ST_STALL;
              cnt_d   = CNT_INIT;
            end
          end
        end
        ST_STALL: begin
          stall_i = 1'b1;
          if (cnt <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt - 3'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, even with a live hazard on the inputs.
  assign stall        = stall_i && reset;
  assign bubble       = stall_i && reset;
  assign id_rf_bypass = byp_raw & {NUM_SRC{reset}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      cnt          <= '0;
      forward_sel  <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (stall_i || flush || !id_valid) begin
        forward_sel <= '0;
      end else begin
        forward_sel <= fsel_d;
      end
      if (stall_i && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: three parameterisations share one stimulus stream; a negedge monitor checks queued expectations.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  ex_write_register;
  logic        me_reg_write;
  logic [4:0]  me_write_register;
  logic        wb_reg_write;
  logic [4:0]  wb_write_register;
  logic        flush;

  logic        stall_a, bubble_a, stall_b, bubble_b, stall_c, bubble_c;
  logic [3:0]  fsel_a, fsel_b, fsel_c;
  logic [1:0]  byp_a, byp_b, byp_c;
  logic [15:0] cnt_a, cnt_c;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG_EN(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_write_register(ex_write_register),
    .me_reg_write(me_reg_write), .me_write_register(me_write_register),
    .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register), .flush(flush),
    .stall(stall_a), .bubble(bubble_a), .forward_sel(fsel_a), .id_rf_bypass(byp_a), .stall_cycles(cnt_a));

  hazard_forward_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG_EN(1), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_write_register(ex_write_register),
    .me_reg_write(me_reg_write), .me_write_register(me_write_register),
    .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register), .flush(flush),
    .stall(stall_b), .bubble(bubble_b), .forward_sel(fsel_b), .id_rf_bypass(byp_b), .stall_cycles(cnt_b));

  hazard_forward_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG_EN(0), .CNT_W(16)) dutz (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_write_register(ex_write_register),
    .me_reg_write(me_reg_write), .me_write_register(me_write_register),
    .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register), .flush(flush),
    .stall(stall_c), .bubble(bubble_c), .forward_sel(fsel_c), .id_rf_bypass(byp_c), .stall_cycles(cnt_c));

  localparam int A_STALL = 0, A_BUB = 1, A_FSEL = 2, A_BYP = 3, A_CNT = 4;
  localparam int B_STALL = 5, B_FSEL = 6, B_CNT = 7, B_BUB = 8, B_BYP = 9;
  localparam int C_STALL = 10, C_FSEL = 11, C_BUB = 12, C_BYP = 13, C_CNT = 14;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      A_STALL: return {31'b0, stall_a};
      A_BUB:   return {31'b0, bubble_a};
      A_FSEL:  return {28'b0, fsel_a};
      A_BYP:   return {30'b0, byp_a};
      A_CNT:   return {16'b0, cnt_a};
      B_STALL: return {31'b0, stall_b};
      B_FSEL:  return {28'b0, fsel_b};
      B_CNT:   return {28'b0, cnt_b};
      B_BUB:   return {31'b0, bubble_b};
      B_BYP:   return {30'b0, byp_b};
      C_STALL: return {31'b0, stall_c};
      C_FSEL:  return {28'b0, fsel_c};
      C_BUB:   return {31'b0, bubble_c};
      C_BYP:   return {30'b0, byp_c};
      C_CNT:   return {16'b0, cnt_c};
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: every expectation due this cycle is compared on the falling edge.
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].sel);
        n_checks++;
        if (act !== sb[i].exp) begin
          n_errors++;
          $display("FAIL %s cycle %0d: got %0h expected %0h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic exp_at(input int d, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.sel  = sel;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src_addr = '0; id_src_used = '0;
    ex_reg_write = 0; ex_mem_read = 0; ex_write_register = '0;
    me_reg_write = 0; me_write_register = '0;
    wb_reg_write = 0; wb_write_register = '0;
    flush = 0;
  endtask

  task automatic load_hazard(input logic [4:0] r);
    id_valid = 1; id_src_addr = {5'd0, r}; id_src_used = 2'b01;
    ex_reg_write = 1; ex_mem_read = 1; ex_write_register = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    step();
    // Reset held with a live hazard and WB match: outputs must stay quiet.
    load_hazard(5'd8);
    wb_reg_write = 1; wb_write_register = 5'd8;
    exp_at(0, A_STALL, 0, "rst_stall");
    exp_at(0, A_BUB,   0, "rst_bubble");
    exp_at(0, A_BYP,   0, "rst_bypass");
    exp_at(0, A_FSEL,  0, "rst_fsel");
    exp_at(0, A_CNT,   0, "rst_cnt");
    exp_at(0, B_STALL, 0, "rst_stall3");
    #1;
    n_checks++;
    if (stall_a !== 1'b0 || byp_a !== 2'b00) begin
      n_errors++;
      $display("FAIL direct_rst_quiet: stall %b bypass %b", stall_a, byp_a);
    end
    step();
    idle();
    reset = 1'b1;

    // Load-use, LOAD_LAT = 1.
    step();
    load_hazard(5'd8);
    exp_at(0, A_STALL, 1, "lu_stall");
    exp_at(0, A_BUB,   1, "lu_bubble");
    #1;
    n_checks++;
    if (stall_a !== 1'b1 || bubble_a !== 1'b1) begin
      n_errors++;
      $display("FAIL direct_lu_stall: stall %b bubble %b", stall_a, bubble_a);
    end
    step();
    ex_reg_write = 0; ex_mem_read = 0; me_reg_write = 1; me_write_register = 5'd8;
    exp_at(0, A_STALL, 0, "lu_stall_end");
    exp_at(0, A_FSEL,  0, "lu_fsel_cleared");
    exp_at(0, A_CNT,   1, "lu_cnt");
    exp_at(1, A_FSEL,  4'b0001, "lu_fsel_mewb");
    step();
    idle();
    exp_at(0, A_CNT,  1, "lu_cnt_hold");
    exp_at(1, A_FSEL, 0, "idle_fsel");

    // Dual-producer priority on operand 1.
    step();
    id_valid = 1; id_src_addr = {5'd5, 5'd0}; id_src_used = 2'b10;
    ex_reg_write = 1; ex_write_register = 5'd5; me_reg_write = 1; me_write_register = 5'd5;
    exp_at(0, A_STALL, 0, "prio_nostall");
    exp_at(1, A_FSEL, 4'b1000, "prio_ex");
    exp_at(1, C_FSEL, 4'b1000, "prio_ex_nz");
    step();
    ex_reg_write = 0;
    exp_at(1, A_FSEL, 4'b0100, "prio_me");

    // Register 0 as producer destination.
    step();
    idle();
    id_valid = 1; id_src_used = 2'b01; ex_reg_write = 1; ex_write_register = 5'd0;
    exp_at(1, A_FSEL, 0, "zero_fsel");
    exp_at(1, C_FSEL, 4'b0010, "zero_fsel_nz");
    step();
    ex_mem_read = 1;
    exp_at(0, A_STALL, 0, "zero_nostall");
    exp_at(0, C_STALL, 1, "zero_stall_nz");

    // WB write-through, with and without a concurrent stall.
    step();
    idle();
    id_valid = 1; id_src_addr = {5'd12, 5'd8}; id_src_used = 2'b10;
    wb_reg_write = 1; wb_write_register = 5'd12;
    exp_at(0, A_BYP, 2'b10, "wb_byp");
    #1;
    n_checks++;
    if (byp_a !== 2'b10) begin
      n_errors++;
      $display("FAIL direct_wb_byp: bypass %b", byp_a);
    end
    step();
    id_src_used = 2'b11; ex_reg_write = 1; ex_mem_read = 1; ex_write_register = 5'd8;
    exp_at(0, A_STALL, 1, "wb_stall");
    exp_at(0, A_BYP, 2'b10, "wb_byp_stall");
    step();
    idle();
    id_valid = 1; id_src_addr = {5'd12, 5'd12}; id_src_used = 2'b01;
    wb_reg_write = 1; wb_write_register = 5'd12;
    exp_at(0, A_BYP, 2'b01, "wb_byp_op0");

    step();
    idle();
    reset = 1'b0;
    exp_at(0, A_CNT, 0, "rst_pulse_cnt");
    step();
    reset = 1'b1;

    // LOAD_LAT = 3 sequence.
    step();
    load_hazard(5'd9);
    exp_at(0, B_STALL, 1, "ll3_s1");
    step();
    ex_reg_write = 0; ex_mem_read = 0; me_reg_write = 1; me_write_register = 5'd9;
    exp_at(0, B_STALL, 1, "ll3_s2");
    exp_at(0, B_BUB,   1, "ll3_bubble_s2");
    step();
    exp_at(0, B_STALL, 1, "ll3_s3");
    exp_at(0, B_FSEL,  0, "ll3_fsel_s3");
    step();
    exp_at(0, B_STALL, 0, "ll3_end");
    exp_at(0, B_CNT,   3, "ll3_cnt");
    exp_at(1, B_FSEL,  4'b0001, "ll3_fsel_after");

    // Flush in the second stall cycle.
    step();
    me_reg_write = 0; ex_reg_write = 1; ex_mem_read = 1; ex_write_register = 5'd9;
    exp_at(0, B_STALL, 1, "fl_s1");
    step();
    ex_reg_write = 0; ex_mem_read = 0; me_reg_write = 1; me_write_register = 5'd9; flush = 1;
    exp_at(0, B_STALL, 0, "fl_drop");
    exp_at(1, B_FSEL,  0, "fl_fsel");
    step();
    flush = 0;
    exp_at(0, B_STALL, 0, "fl_run");
    exp_at(0, B_CNT,   4, "fl_cnt");
    exp_at(1, B_FSEL,  4'b0001, "fl_fsel_run");

    // Continuous hazard drives the 4-bit counter into saturation.
    step();
    idle();
    load_hazard(5'd9);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) exp_at(0, B_CNT, 14, "sat_pre");
    end
    exp_at(0, B_CNT,   15, "sat_cnt");
    exp_at(0, B_STALL, 1,  "sat_stall");

    // Asynchronous reset in the middle of a stall.
    step();
    reset = 1'b0;
    exp_at(0, B_CNT,   0, "rst_async_cnt");
    exp_at(0, B_STALL, 0, "rst_async_stall");
    step();
    idle();
    reset = 1'b1;
    exp_at(0, B_STALL, 0, "no_residual");
    exp_at(0, B_CNT,   0, "no_residual_cnt");
    #1;
    n_checks++;
    if (stall_b !== 1'b0 || cnt_b !== 4'd0) begin
      n_errors++;
      $display("FAIL direct_no_residual: stall %b cnt %0d", stall_b, cnt_b);
    end

    step();
    step();
    step();
    while (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: never compared, due cycle %0d expected %0h", sb[0].name, sb[0].cyc, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
